// File: rtl/mult_div_controller.sv
// Sequencer for the shared multi-cycle multiply/divide unit and the HI/LO pair in EX.
// Accepts one MDU op per start, models a fixed latency, and commits HI/LO on the last busy cycle.
module mult_div_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startInEX,
    input  logic [2:0]  mdOpInEX,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        mdUseInID,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stallMD,
    output logic [1:0]  dbgState
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [31:0]   pendA;
    logic [31:0]   pendB;
    logic          pendSigned;

    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] magQ;
    logic [31:0] magR;

    // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        if (pendSigned)
            product = $signed({{32{pendA[31]}}, pendA}) * $signed({{32{pendB[31]}}, pendB});
        else
            product = {32'd0, pendA} * {32'd0, pendB};
        negA      = pendSigned & pendA[31];
        negB      = pendSigned & pendB[31];
        magA      = negA ? (32'd0 - pendA) : pendA;
        magB      = negB ? (32'd0 - pendB) : pendB;
        magQ      = (magB == 32'd0) ? 32'd0 : magA / magB;
        magR      = (magB == 32'd0) ? 32'd0 : magA % magB;
        quotient  = (negA ^ negB) ? (32'd0 - magQ) : magQ;
        remainder = negA ? (32'd0 - magR) : magR;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            counter    <= '0;
            busy       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            pendA      <= 32'd0;
            pendB      <= 32'd0;
            pendSigned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startInEX) begin
                        case (mdOpInEX)
                            3'd0, 3'd1: begin
                                pendA      <= operandA;
                                pendB      <= operandB;
                                pendSigned <= (mdOpInEX == 3'd0);
                                counter    <= CW'(MULT_CYCLES - 1);
                                state      <= MULT;
                                busy       <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                pendA      <= operandA;
                                pendB      <= operandB;
                                pendSigned <= (mdOpInEX == 3'd2);
                                counter    <= CW'(DIV_CYCLES - 1);
                                state      <= DIV;
                                busy       <= 1'b1;
                            end
                            3'd4: hi <= operandA;
                            3'd5: lo <= operandA;
                            default: ;
                        endcase
                    end
                end
                MULT: begin
                    if (counter == '0) begin
                        hi    <= product[63:32];
                        lo    <= product[31:0];
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                DIV: begin
                    if (counter == '0) begin
                        // A zero divisor leaves HI/LO untouched but still burns the full latency.
                        if (pendB != 32'd0) begin
                            hi <= remainder;
                            lo <= quotient;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Handshake: ID is held whenever it needs HI/LO while an op is running or just being launched.
    assign stallMD  = mdUseInID & (busy | (startInEX & (mdOpInEX <= 3'd3)));
    assign dbgState = state;

endmodule

// File: tb/tb_mult_div_controller.sv
// Directed plus randomized bench for mult_div_controller against an arithmetic model of HI/LO.
module tb_mult_div_controller;

    logic        clk;
    logic        resetN;
    logic        startInEX;
    logic [2:0]  mdOpInEX;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        mdUseInID;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stallMD;
    logic [1:0]  dbgState;

    int errors = 0;
    int checks = 0;
    logic [31:0] expHi = 32'd0;
    logic [31:0] expLo = 32'd0;

    mult_div_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .startInEX (startInEX),
        .mdOpInEX  (mdOpInEX),
        .operandA  (operandA),
        .operandB  (operandB),
        .mdUseInID (mdUseInID),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .stallMD   (stallMD),
        .dbgState  (dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: HI/LO computed directly from the arithmetic rules with 64-bit integers.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr, sp;
        longint unsigned up;
        case (op)
            3'd0: begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                sp = sa * sb;
                expHi = sp[63:32];
                expLo = sp[31:0];
            end
            3'd1: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                expHi = up[63:32];
                expLo = up[31:0];
            end
            3'd2: if (b != 32'd0) begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                sq = sa / sb;
                sr = sa % sb;
                expLo = sq[31:0];
                expHi = sr[31:0];
            end
            3'd3: if (b != 32'd0) begin
                expLo = a / b;
                expHi = a % b;
            end
            3'd4: expHi = a;
            3'd5: expLo = a;
            default: ;
        endcase
    endtask

    function automatic int op_cycles(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    // Called at a negedge; launches one op, watches busy/stallMD, and checks HI/LO on completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int cycles;
        startInEX = 1'b1;
        mdOpInEX  = op;
        operandA  = a;
        operandB  = b;
        mdUseInID = 1'b1;
        #1;
        check("stall_launch", {63'd0, stallMD}, {63'd0, (op <= 3'd3)});
        @(negedge clk);
        startInEX = 1'b0;
        mdOpInEX  = 3'($urandom_range(0, 7));
        operandA  = $urandom;
        operandB  = $urandom;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            check("stall_busy", {63'd0, stallMD}, 64'd1);
            if (inject && cycles == 3) begin
                startInEX = 1'b1;
                mdOpInEX  = 3'd0;
            end
            cycles++;
            @(negedge clk);
            startInEX = 1'b0;
            operandA  = $urandom;
            operandB  = $urandom;
        end
        check("busy_len", 64'(cycles), 64'(op_cycles(op)));
        model_apply(op, a, b);
        check("stall_after", {63'd0, stallMD}, 64'd0);
        check("hi", {32'd0, hi}, {32'd0, expHi});
        check("lo", {32'd0, lo}, {32'd0, expLo});
        mdUseInID = 1'b0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        resetN    = 1'b0;
        startInEX = 1'b0;
        mdOpInEX  = 3'd0;
        operandA  = 32'd0;
        operandB  = 32'd0;
        mdUseInID = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_stall", {63'd0, stallMD}, 64'd0);
        resetN = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        check("mult_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        check("multu_hi_const", {32'd0, hi}, 64'h0000_0000_0000_0001);
        run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        check("div_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd0, 1'b0);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd4, 32'h12345678, 32'd0, 1'b0);
        check("mthi_const", {32'd0, hi}, 64'h0000_0000_1234_5678);
        run_op(3'd5, 32'hCAFEF00D, 32'd0, 1'b0);
        run_op(3'd6, 32'hDEADBEEF, 32'h1, 1'b0);
        run_op(3'd7, 32'hDEADBEEF, 32'h1, 1'b0);
        run_op(3'd2, 32'd1000, 32'hFFFFFFF9, 1'b1);

        // Reset in the middle of a divide: everything clears at once, nothing is committed.
        startInEX = 1'b1;
        mdOpInEX  = 3'd2;
        operandA  = 32'd100;
        operandB  = 32'd3;
        @(negedge clk);
        startInEX = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        expHi = 32'd0;
        expLo = 32'd0;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hi", {32'd0, hi}, 64'd0);
        check("rst_mid_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check("rst_idle_after", {63'd0, busy}, 64'd0);
        run_op(3'd0, 32'd3, 32'd4, 1'b0);
        check("post_rst_lo", {32'd0, lo}, 64'd12);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
